// File: rtl/uart_rx_bit_timer.sv
// Oversampling bit/edge timer for the UART receiver: counts clocks per bit and bits per frame,
// decodes sample strobes, bit-end and frame-end. Define UART_RX_BIT_TIMER_MAJORITY_EN for 3-point sampling.
module uart_rx_bit_timer #(
   parameter int PRESCALE_W = 6,
   parameter int BIT_CNT_W  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  restart,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic [BIT_CNT_W-1:0]  frame_bits,
   output logic [PRESCALE_W-1:0] edge_cnt,
   output logic [BIT_CNT_W-1:0]  bit_cnt,
   output logic                  sample_strobe,
   output logic [1:0]            sample_idx,
   output logic                  bit_done,
   output logic                  frame_done,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [PRESCALE_W-1:0] PS_MIN = PRESCALE_W'(4);
   localparam logic [BIT_CNT_W-1:0]  FB_MIN = BIT_CNT_W'(1);

   state_t                  state, state_nx;
   logic [PRESCALE_W-1:0]   edge_nx;
   logic [BIT_CNT_W-1:0]    bit_nx;
   logic [PRESCALE_W-1:0]   ps_q, ps_nx;
   logic [BIT_CNT_W-1:0]    fb_q, fb_nx;
   logic [PRESCALE_W-1:0]   ps_clamped;
   logic [BIT_CNT_W-1:0]    fb_clamped;
   logic [PRESCALE_W-1:0]   mid;
   logic                    last_edge;
   logic                    last_bit;
   logic                    counting;

   assign ps_clamped = (prescale < PS_MIN) ? PS_MIN : prescale;
   assign fb_clamped = (frame_bits < FB_MIN) ? FB_MIN : frame_bits;
   assign mid        = ps_q >> 1;
   assign last_edge  = (edge_cnt == ps_q - PRESCALE_W'(1));
   assign last_bit   = (bit_cnt == fb_q - BIT_CNT_W'(1));
   assign counting   = (state == COUNT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         edge_cnt <= '0;
         bit_cnt  <= '0;
         ps_q     <= PS_MIN;
         fb_q     <= FB_MIN;
      end else begin
         state    <= state_nx;
         edge_cnt <= edge_nx;
         bit_cnt  <= bit_nx;
         ps_q     <= ps_nx;
         fb_q     <= fb_nx;
      end
   end

   // Priority: enable low beats restart, which beats normal counting.
   always_comb begin
      state_nx = state;
      edge_nx  = edge_cnt;
      bit_nx   = bit_cnt;
      ps_nx    = ps_q;
      fb_nx    = fb_q;
      if (!enable) begin
         state_nx = IDLE;
         edge_nx  = '0;
         bit_nx   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nx = COUNT;
               edge_nx  = '0;
               bit_nx   = '0;
               ps_nx    = ps_clamped;
               fb_nx    = fb_clamped;
            end
            COUNT, DONE: begin
               if (restart) begin
                  state_nx = COUNT;
                  edge_nx  = '0;
                  bit_nx   = '0;
                  ps_nx    = ps_clamped;
                  fb_nx    = fb_clamped;
               end else if (state == COUNT) begin
                  if (last_edge) begin
                     edge_nx = '0;
                     if (last_bit) begin
                        state_nx = DONE;
                        bit_nx   = fb_q;
                     end else begin
                        bit_nx = bit_cnt + BIT_CNT_W'(1);
                     end
                  end else begin
                     edge_nx = edge_cnt + PRESCALE_W'(1);
                  end
               end
            end
            default: begin
               state_nx = IDLE;
               edge_nx  = '0;
               bit_nx   = '0;
            end
         endcase
      end
   end

   assign busy       = counting;
   assign bit_done   = counting && last_edge;
   assign frame_done = counting && last_edge && last_bit;

`ifdef UART_RX_BIT_TIMER_MAJORITY_EN
   // Three strobes centred on mid feed a 2-of-3 voter; idx tags which one.
   always_comb begin
      sample_strobe = 1'b0;
      sample_idx    = 2'd1;
      if (counting) begin
         if (edge_cnt == mid - PRESCALE_W'(1)) begin
            sample_strobe = 1'b1;
            sample_idx    = 2'd0;
         end else if (edge_cnt == mid) begin
            sample_strobe = 1'b1;
            sample_idx    = 2'd1;
         end else if (edge_cnt == mid + PRESCALE_W'(1)) begin
            sample_strobe = 1'b1;
            sample_idx    = 2'd2;
         end
      end
   end
`else
   assign sample_strobe = counting && (edge_cnt == mid);
   assign sample_idx    = 2'd1;
`endif

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// Directed self-checking bench for uart_rx_bit_timer; expected strobe pattern follows
// UART_RX_BIT_TIMER_MAJORITY_EN so the bench matches whichever build it is compiled with.
module tb_uart_rx_bit_timer;

   logic       clk;
   logic       rst;
   logic       enable;
   logic       restart;
   logic [5:0] prescale;
   logic [3:0] frame_bits;
   logic [5:0] edge_cnt;
   logic [3:0] bit_cnt;
   logic       sample_strobe;
   logic [1:0] sample_idx;
   logic       bit_done;
   logic       frame_done;
   logic       busy;

   int    n_cmp = 0;
   int    n_err = 0;
   string phase = "init";

   uart_rx_bit_timer #(
      .PRESCALE_W(6),
      .BIT_CNT_W (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .restart      (restart),
      .prescale     (prescale),
      .frame_bits   (frame_bits),
      .edge_cnt     (edge_cnt),
      .bit_cnt      (bit_cnt),
      .sample_strobe(sample_strobe),
      .sample_idx   (sample_idx),
      .bit_done     (bit_done),
      .frame_done   (frame_done),
      .busy         (busy)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s [%s]: got %0d expected %0d", tag, phase, obs, exp);
      end
   endtask

   // Reference strobe model derived from the bit length the frame was started with.
   task automatic exp_strobe(input int e, input int ps, output int s, output int idx);
      int mid;
      mid = ps / 2;
`ifdef UART_RX_BIT_TIMER_MAJORITY_EN
      s   = (e >= mid - 1 && e <= mid + 1) ? 1 : 0;
      idx = (s == 1) ? e - (mid - 1) : 1;
`else
      s   = (e == mid) ? 1 : 0;
      idx = 1;
`endif
   endtask

   task automatic expect_count(input int e, input int b, input int ps, input int fb);
      int s, idx;
      exp_strobe(e, ps, s, idx);
      check("edge_cnt",      32'(edge_cnt),      e);
      check("bit_cnt",       32'(bit_cnt),       b);
      check("busy",          32'(busy),          1);
      check("bit_done",      32'(bit_done),      (e == ps - 1) ? 1 : 0);
      check("frame_done",    32'(frame_done),    (e == ps - 1 && b == fb - 1) ? 1 : 0);
      check("sample_strobe", 32'(sample_strobe), s);
      check("sample_idx",    32'(sample_idx),    idx);
   endtask

   task automatic expect_quiet(input int e, input int b);
      check("edge_cnt",      32'(edge_cnt),      e);
      check("bit_cnt",       32'(bit_cnt),       b);
      check("busy",          32'(busy),          0);
      check("bit_done",      32'(bit_done),      0);
      check("frame_done",    32'(frame_done),    0);
      check("sample_strobe", 32'(sample_strobe), 0);
      check("sample_idx",    32'(sample_idx),    1);
   endtask

   // Checks n consecutive COUNT cycles from cycle 0, ticking after each.
   task automatic run_cycles(input int n, input int ps, input int fb);
      for (int c = 0; c < n; c++) begin
         expect_count(c % ps, c / ps, ps, fb);
         tick();
      end
   endtask

   task automatic run_frame(input int ps, input int fb);
      run_cycles(ps * fb, ps, fb);
      expect_quiet(0, fb);
   endtask

   initial begin
      rst        = 1'b1;
      enable     = 1'b0;
      restart    = 1'b0;
      prescale   = 6'd8;
      frame_bits = 4'd10;

      phase = "reset";
      tick();
      tick();
      expect_quiet(0, 0);
      rst = 1'b0;
      phase = "idle_hold";
      for (int i = 0; i < 20; i++) begin
         tick();
         expect_quiet(0, 0);
      end

      // Full 8x10 frame; input changes mid-frame must not disturb it.
      phase = "frame_8x10";
      enable = 1'b1;
      tick();
      run_cycles(40, 8, 10);
      prescale   = 6'd3;
      frame_bits = 4'd2;
      for (int c = 40; c < 80; c++) begin
         expect_count(c % 8, c / 8, 8, 10);
         tick();
      end
      expect_quiet(0, 10);
      phase = "done_hold";
      for (int i = 0; i < 5; i++) begin
         tick();
         expect_quiet(0, 10);
      end
      enable = 1'b0;
      tick();
      expect_quiet(0, 0);

      // Clamping: prescale 2 -> 4, frame_bits 0 -> 1; then restart from DONE.
      phase = "clamp";
      prescale   = 6'd2;
      frame_bits = 4'd0;
      enable     = 1'b1;
      tick();
      run_frame(4, 1);
      phase = "restart_done";
      restart = 1'b1;
      tick();
      restart = 1'b0;
      run_frame(4, 1);
      enable = 1'b0;
      tick();
      expect_quiet(0, 0);

      // Restart mid-frame with a new prescale.
      phase = "restart_mid";
      prescale   = 6'd8;
      frame_bits = 4'd10;
      enable     = 1'b1;
      tick();
      run_cycles(29, 8, 10);
      expect_count(5, 3, 8, 10);
      prescale = 6'd16;
      restart  = 1'b1;
      tick();
      restart = 1'b0;
      run_cycles(32, 16, 10);
      enable = 1'b0;
      tick();
      expect_quiet(0, 0);

      // enable low wins over restart; restart in IDLE does nothing.
      phase = "restart_vs_enable";
      prescale = 6'd8;
      enable   = 1'b1;
      tick();
      run_cycles(29, 8, 10);
      expect_count(5, 3, 8, 10);
      enable  = 1'b0;
      restart = 1'b1;
      tick();
      expect_quiet(0, 0);
      tick();
      expect_quiet(0, 0);
      restart = 1'b0;

      // Synchronous reset in the middle of bit 4, enable left high.
      phase = "rst_in_count";
      enable = 1'b1;
      tick();
      run_cycles(34, 8, 10);
      expect_count(2, 4, 8, 10);
      rst = 1'b1;
      tick();
      expect_quiet(0, 0);
      rst = 1'b0;
      tick();
      run_cycles(12, 8, 10);
      enable = 1'b0;
      tick();
      expect_quiet(0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
